// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request in
// flight, buffers one returned instruction for decode, and squashes wrong-path fetches.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  RedirectE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  ValidF
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MSK = ~DATA_WIDTH'(3);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t                state_q,     state_d;
    logic [DATA_WIDTH-1:0] pc_q,        pc_d;
    logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [DATA_WIDTH-1:0] buf_pc_q,    buf_pc_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  consume;
    logic                  can_issue;
    logic                  fire;
    logic [DATA_WIDTH-1:0] redirect_pc;

    always_comb begin
        consume     = buf_valid_q && !StallF;
        can_issue   = !buf_valid_q || consume;
        redirect_pc = PCTargetE & ALIGN_MSK;
        imem_req    = 1'b0;
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q && !consume;

        // rst_n gates the request so nothing leaves the stage while reset is held.
        case (state_q)
            S_REQ: begin
                imem_req = can_issue && rst_n;
                if (imem_req && imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    buf_instr_d = imem_rdata;
                    buf_pc_d    = pc_q;
                    buf_valid_d = 1'b1;
                    pc_d        = pc_q + PC_STEP;
                    state_d     = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        fire = imem_req && imem_gnt;

        // A redirect beats stalls and fills; an in-flight request must be drained via DROP.
        if (RedirectE) begin
            pc_d        = redirect_pc;
            buf_valid_d = 1'b0;
            buf_instr_d = buf_instr_q;
            buf_pc_d    = buf_pc_q;
            case (state_q)
                S_REQ:          state_d = fire ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc_q    <= RESET_PC;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign ValidF    = buf_valid_q;
    assign InstrF    = buf_valid_q ? buf_instr_q : NOP_INSTR;
    assign PCF       = buf_pc_q;
    assign PCPlus4F  = buf_pc_q + PC_STEP;

endmodule
